edge_pack16: RTL and testbench

//  Receive side of the 1-bit edge-map stream (din/din_vld/din_sop/din_eop) produced by the

---
 rtl/edge_pack16.sv | 110 +++++++++++
 tb/tb_edge_pack16.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/edge_pack16.sv
// edge_pack16: packs a 1-bit edge stream into words and queues them in a show-ahead FIFO
module edge_pack16 #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_din,
  input  logic              i_din_vld,
  input  logic              i_din_sop,
  input  logic              i_din_eop,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_vld,
  output logic              o_dout_sop,
  output logic              o_dout_eop,
  input  logic              i_dout_rdy,
  output logic              o_frame_err,
  output logic              o_overflow,
  input  logic              i_ovf_clr
);
  localparam int CW = $clog2(DATA_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, PACK} state_t;
  state_t              r_state, w_nstate;
  logic [CW-1:0]       r_cnt, w_ncnt;
  logic [DATA_W-1:0]   r_shift, w_nshift, w_word;
  logic                r_sop_pend, w_nsop;
  logic                w_push, w_psop, w_peop, w_ferr;
  logic                r_frame_err, r_ovf;
  logic [DATA_W+1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wp, r_rp;
  logic                w_empty, w_full, w_pop, w_wr, w_drop;
  logic                w_sop_beat, w_pack_beat, w_last;
  assign w_sop_beat  = i_din_vld & i_din_sop;
  assign w_pack_beat = i_din_vld & !i_din_sop & (r_state == PACK);
  assign w_last      = r_cnt == CW'(DATA_W - 1);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nstate;
  // next state: a sop always (re)starts a frame, eop always ends it
  always_comb begin
    w_nstate = r_state;
    if (w_sop_beat) w_nstate = i_din_eop ? IDLE : PACK;
    else if (w_pack_beat & i_din_eop) w_nstate = IDLE;
  end
  // packing datapath outputs: word to push, next shift/count, framing error
  always_comb begin
    w_word   = r_shift | (DATA_W'(i_din) << r_cnt);
    w_psop   = r_sop_pend;
    w_peop   = i_din_eop;
    w_push   = 1'b0;
    w_ferr   = 1'b0;
    w_ncnt   = r_cnt;
    w_nshift = r_shift;
    w_nsop   = r_sop_pend;
    if (w_sop_beat) begin
      w_ferr = r_state == PACK;
      w_word = DATA_W'(i_din);
      w_psop = 1'b1;
      w_push = i_din_eop;
      w_ncnt = i_din_eop ? '0 : CW'(1);
      w_nshift = i_din_eop ? '0 : DATA_W'(i_din);
      w_nsop = !i_din_eop;
    end else if (w_pack_beat) begin
      w_push   = w_last | i_din_eop;
      w_ncnt   = i_din_eop ? '0 : r_cnt + CW'(1);
      w_nshift = w_push ? '0 : w_word;
      w_nsop   = w_push ? 1'b0 : r_sop_pend;
    end else if (i_din_vld & i_din_eop) begin
      w_ferr = 1'b1;
    end
  end
  // packing registers and framing-error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_sop_pend  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cnt       <= w_ncnt;
      r_shift     <= w_nshift;
      r_sop_pend  <= w_nsop;
      r_frame_err <= w_ferr;
    end
  assign w_empty = r_wp == r_rp;
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = !w_empty & i_dout_rdy;
  assign w_wr    = w_push & (!w_full | w_pop);
  assign w_drop  = w_push & w_full & !w_pop;
  // FIFO storage; contents need no reset since the head is masked when empty
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= {w_psop, w_peop, w_word};
  // FIFO pointers and sticky overflow (a new drop beats a clear)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wp  <= r_wp + (AW+1)'(w_wr);
      r_rp  <= r_rp + (AW+1)'(w_pop);
      r_ovf <= w_drop | (r_ovf & !i_ovf_clr);
    end
  assign {o_dout_sop, o_dout_eop, o_dout} = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign o_dout_vld  = !w_empty;
  assign o_frame_err = r_frame_err;
  assign o_overflow  = r_ovf;
endmodule

// File: tb/tb_edge_pack16.sv
// tb_edge_pack16: random and directed stimulus against a bit-queue reference model
module tb_edge_pack16;
  logic clk = 0, rst_n = 0;
  logic din = 0, din_vld = 0, din_sop = 0, din_eop = 0, dout_rdy = 0, ovf_clr = 0;
  logic [15:0] dout;
  logic dout_vld, dout_sop, dout_eop, frame_err, overflow;
  int n_chk = 0, n_err = 0;
  logic [17:0] q[$];
  bit mbits[$];
  bit in_frame = 0, sop_pend = 0, ovf_m = 0, ferr_m = 0;

  edge_pack16 dut (
    .clk(clk), .rst_n(rst_n), .i_din(din), .i_din_vld(din_vld), .i_din_sop(din_sop),
    .i_din_eop(din_eop), .o_dout(dout), .o_dout_vld(dout_vld), .o_dout_sop(dout_sop),
    .o_dout_eop(dout_eop), .i_dout_rdy(dout_rdy), .o_frame_err(frame_err),
    .o_overflow(overflow), .i_ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_head();
    return q.size() ? {13'd0, 1'b1, q[0]} : 32'd0;
  endfunction

  task automatic model_reset();
    q.delete(); mbits.delete();
    in_frame = 0; sop_pend = 0; ovf_m = 0; ferr_m = 0;
  endtask

  task automatic step(input bit d, input bit v, input bit s, input bit e, input bit r, input bit c);
    bit pop, push, ovf_new, take;
    logic [15:0] w;
    logic [17:0] pw;
    din = d; din_vld = v; din_sop = s; din_eop = e; dout_rdy = r; ovf_clr = c;
    @(posedge clk);
    pop = q.size() > 0 && r;
    push = 0; ovf_new = 0; ferr_m = 0; pw = '0;
    if (v) begin
      take = 1;
      if (s) begin
        ferr_m = in_frame;
        mbits.delete();
        in_frame = 1; sop_pend = 1;
      end else if (!in_frame) begin
        ferr_m = e;
        take = 0;
      end
      if (take) begin
        mbits.push_back(d);
        if (mbits.size() == 16 || e) begin
          w = '0;
          foreach (mbits[k]) w[k] = mbits[k];
          pw = {sop_pend, e, w};
          push = 1;
          mbits.delete();
          sop_pend = 0;
          if (e) in_frame = 0;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < 4) q.push_back(pw);
      else ovf_new = 1;
    end
    ovf_m = ovf_new ? 1'b1 : (c ? 1'b0 : ovf_m);
    #1;
    chk("head", {13'd0, dout_vld, dout_sop, dout_eop, dout}, exp_head());
    chk("flags", {30'd0, overflow, frame_err}, {30'd0, ovf_m, ferr_m});
  endtask

  task automatic frame(input int n, input int mode, input bit gaps, input bit r);
    bit d;
    for (int i = 0; i < n; i++) begin
      d = mode == 0 ? i[0] : (mode == 1 ? 1'b1 : 1'($urandom));
      step(d, 1, i == 0, i == n - 1, r, 0);
      if (gaps) step(1'($urandom), 0, 1'($urandom), 1'($urandom), r, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    #1;
    chk("reset_out", {13'd0, dout_vld, dout_sop, dout_eop, dout, overflow, frame_err}, 32'd0);
    #20 rst_n = 1;
    // 1: alternating pattern, two 0xAAAA words
    frame(32, 0, 0, 0);
    chk("t1_w0", {14'd0, dout_sop, dout_eop, dout}, {14'd0, 2'b10, 16'hAAAA});
    step(0, 0, 0, 0, 1, 0);
    chk("t1_w1", {14'd0, dout_sop, dout_eop, dout}, {14'd0, 2'b01, 16'hAAAA});
    idle(3);
    // 2: 20 ones, padded second word
    frame(20, 1, 0, 1);
    idle(3);
    // 3: single-beat frame
    step(1, 1, 1, 1, 0, 0);
    chk("t3_word", {13'd0, dout_vld, dout_sop, dout_eop, dout}, {13'd0, 3'b111, 16'h0001});
    idle(3);
    // 4: stalled sink, six words into a four-deep FIFO
    for (int f = 0; f < 6; f++) frame(16, 2, 0, 0);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("t4_clr", {31'd0, overflow}, 32'd0);
    idle(6);
    // 5: sop arriving mid-frame
    for (int i = 0; i < 10; i++) step(1'($urandom), 1, i == 0, 0, 1, 0);
    frame(16, 1, 0, 1);
    idle(3);
    // 6: valid gaps, then reset mid-frame
    frame(24, 2, 1, 1);
    idle(2);
    for (int i = 0; i < 7; i++) step(1'($urandom), 1, i == 0, 0, 0, 0);
    rst_n = 0;
    #2;
    chk("t6_rst", {13'd0, dout_vld, dout_sop, dout_eop, dout, overflow, frame_err}, 32'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1;
    frame(18, 1, 0, 1);
    idle(3);
    // random traffic, alternating sink pressure
    for (int i = 0; i < 1500; i++)
      step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 24) == 0, (i / 300) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
